multiplication_result_formatter: RTL

//  Downstream stage of fast_multiplication. Converts its sign-magnitude 128b product to two's complement.

---
 rtl/multiplication_result_formatter.sv | 118 +++++++++++
 1 files changed

// File: rtl/multiplication_result_formatter.sv
// multiplication_result_formatter: sign-magnitude 128b product to two's complement 64b result, credit-gated result FIFO
// Optional MULT_FORMATTER_OUTPUT_REG_EN: negation and half-select split over two registered stages (latency 2).
module multiplication_result_formatter #(
    parameter int OPERAND_WIDTH_IN_BITS = 64,
    parameter int PRODUCT_WIDTH_IN_BITS = 128,
    parameter int RESULT_DEPTH          = 4
) (
    input  logic                             clk_in,
    input  logic                             reset_in,
    input  logic                             issue_valid_in,
    input  logic [1:0]                       issue_op_in,
    output logic                             issue_ready_out,
    input  logic                             product_valid_in,
    input  logic                             product_sign_bit_in,
    input  logic [PRODUCT_WIDTH_IN_BITS-1:0] product_in,
    output logic                             result_valid_out,
    input  logic                             result_ready_in,
    output logic [OPERAND_WIDTH_IN_BITS-1:0] result_out,
    output logic                             error_out
);
    localparam int OW = OPERAND_WIDTH_IN_BITS;
    localparam int PW = PRODUCT_WIDTH_IN_BITS;
    localparam int AW = $clog2(RESULT_DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    logic [AW:0]   credits;
    logic          issue_fire;
    logic          result_fire;
    logic [1:0]    tag_mem [RESULT_DEPTH];
    logic [AW:0]   tag_wr;
    logic [AW:0]   tag_rd;
    logic          tag_empty;
    logic          tag_pop;
    logic [1:0]    tag_head;
    logic          err_now;
    logic [PW-1:0] full;
    logic          buf_push;
    logic [OW-1:0] buf_data;
    logic [OW-1:0] res_mem [RESULT_DEPTH];
    logic [AW:0]   res_wr;
    logic [AW:0]   res_rd;
    logic          res_empty;

    assign issue_ready_out  = credits != '0;
    assign issue_fire       = issue_valid_in & issue_ready_out;
    assign result_fire      = result_valid_out & result_ready_in;
    assign tag_empty        = tag_wr == tag_rd;
    assign tag_pop          = product_valid_in & ~tag_empty;
    assign tag_head         = tag_mem[tag_rd[AW-1:0]];
    assign err_now          = product_valid_in & (tag_empty | (tag_head == 2'b11 & product_sign_bit_in));
    assign full             = product_sign_bit_in ? ~product_in + PW'(1) : product_in;
    assign res_empty        = res_wr == res_rd;
    assign result_valid_out = ~res_empty;
    assign result_out       = res_empty ? '0 : res_mem[res_rd[AW-1:0]];

    // credit counter: one credit per op in flight anywhere between issue and consumer
    always_ff @(posedge clk_in) begin
        if (reset_in) credits <= (AW+1)'(RESULT_DEPTH);
        else credits <= credits - (issue_fire ? ONE : '0) + (result_fire ? ONE : '0);
    end

    // op tag FIFO: pushed at issue, popped as each product returns
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            tag_wr <= '0;
            tag_rd <= '0;
        end else begin
            if (issue_fire) begin
                tag_mem[tag_wr[AW-1:0]] <= issue_op_in;
                tag_wr <= tag_wr + ONE;
            end
            if (tag_pop) tag_rd <= tag_rd + ONE;
        end
    end

    // sticky protocol error: orphan product or MULHU with a negative product
    always_ff @(posedge clk_in) begin
        if (reset_in) error_out <= 1'b0;
        else if (err_now) error_out <= 1'b1;
    end

`ifdef MULT_FORMATTER_OUTPUT_REG_EN
    logic          s1_valid;
    logic [PW-1:0] s1_full;
    logic [1:0]    s1_op;

    // stage 1 holds the negated product and its tag; the half select happens on the way into the buffer
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= tag_pop;
            s1_full  <= full;
            s1_op    <= tag_head;
        end
    end

    assign buf_push = s1_valid;
    assign buf_data = s1_op == 2'b00 ? s1_full[OW-1:0] : s1_full[PW-1:OW];
`else
    assign buf_push = tag_pop;
    assign buf_data = tag_head == 2'b00 ? full[OW-1:0] : full[PW-1:OW];
`endif

    // result buffer: circular FIFO with an extra pointer bit telling full from empty
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            res_wr <= '0;
            res_rd <= '0;
        end else begin
            if (buf_push) begin
                res_mem[res_wr[AW-1:0]] <= buf_data;
                res_wr <= res_wr + ONE;
            end
            if (result_fire) res_rd <= res_rd + ONE;
        end
    end
endmodule
